// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding scoreboard.
//   hz_rec_t   : per-stage in-flight record (valid, destination, remaining Tnew, MD flag)
//   sel_width  : forward-select width for a given tracked depth
//   FWD_*      : forward-select codes (0 = register file / pipeline register value)
//   *_CYC_DEF  : default multiply/divide busy lengths
package hazard_pkg;

  // Record tnew storage width; the scoreboard's TW parameter must not exceed it.
  localparam int unsigned TnewW = 4;

  localparam int unsigned FWD_RF = 0;
  localparam int unsigned FWD_E  = 1;
  localparam int unsigned FWD_M  = 2;
  localparam int unsigned FWD_W  = 3;

  localparam int unsigned MUL_CYC_DEF = 5;
  localparam int unsigned DIV_CYC_DEF = 10;

  typedef struct packed {
    logic             valid;
    logic [4:0]       dst;
    logic [TnewW-1:0] tnew;
    logic             md;
  } hz_rec_t;

  function automatic int unsigned sel_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Youngest-match search over the in-flight records.
//   src_i   : source register number to look up
//   recs_i  : records, index k-1 holds stage k
//   hit_o   : a valid record in stages FirstStage..Depth writes src_i (src_i != 0)
//   stage_o : stage number of the youngest (smallest k) matching record
//   tnew_o  : remaining Tnew of that record
module hazard_match
  import hazard_pkg::*;
#(
  parameter int unsigned Depth      = 3,
  parameter int unsigned FirstStage = 1,
  localparam int unsigned SelW      = sel_width(Depth)
) (
  input  logic [4:0]       src_i,
  input  hz_rec_t          recs_i [Depth],
  output logic             hit_o,
  output logic [SelW-1:0]  stage_o,
  output logic [TnewW-1:0] tnew_o
);

  always_comb begin
    hit_o   = 1'b0;
    stage_o = '0;
    tnew_o  = '0;
    // Scan oldest to youngest so the youngest match overwrites the others.
    for (int k = int'(Depth); k >= int'(FirstStage); k--) begin
      if (recs_i[k-1].valid && (recs_i[k-1].dst == src_i) && (src_i != 5'd0)) begin
        hit_o   = 1'b1;
        stage_o = SelW'(k);
        tnew_o  = recs_i[k-1].tnew;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding unit for the pipelined MIPS core.
// Tracks one record per stage after D (stage 1 = E .. stage DEPTH = W), raises the D-stage
// stall from Tuse/Tnew and MD-unit occupancy, and produces forward selects for D and E operands.
//   clk, rst_n           : clock, asynchronous active-low reset
//   d_valid              : D holds a real instruction
//   d_src_addr/used/tuse : per-source register, read flag, cycles until consumed
//   d_dst_addr/d_dst_tnew: destination (0 = none), cycles after E until result exists
//   d_md_start/div/use   : MD start, division select, any HI/LO access
//   flush                : kill stages 1..DEPTH-1
//   stall                : freeze PC and F/D, bubble into E
//   fwd_sel_d/fwd_sel_e  : per-source forward stage (0 = no forwarding)
//   md_busy              : MD unit still computing
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NSRC    = 2,
  parameter int unsigned DEPTH   = 3,
  parameter int unsigned TW      = 2,
  parameter int unsigned MUL_CYC = MUL_CYC_DEF,
  parameter int unsigned DIV_CYC = DIV_CYC_DEF,
  localparam int unsigned SELW   = sel_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 d_valid,
  input  logic [NSRC*5-1:0]    d_src_addr,
  input  logic [NSRC-1:0]      d_src_used,
  input  logic [NSRC*TW-1:0]   d_src_tuse,
  input  logic [4:0]           d_dst_addr,
  input  logic [TW-1:0]        d_dst_tnew,
  input  logic                 d_md_start,
  input  logic                 d_md_div,
  input  logic                 d_md_use,
  input  logic                 flush,
  output logic                 stall,
  output logic [NSRC*SELW-1:0] fwd_sel_d,
  output logic [NSRC*SELW-1:0] fwd_sel_e,
  output logic                 md_busy
);

  localparam int unsigned MdMax = (DIV_CYC > MUL_CYC) ? DIV_CYC : MUL_CYC;
  localparam int unsigned CntW  = $clog2(MdMax + 1);

  hz_rec_t         recs_q [DEPTH];
  hz_rec_t         recs_d [DEPTH];
  // Stage-1-only fields: the E-stage sources and the MD kind.
  logic [4:0]      e_src_q [NSRC];
  logic [4:0]      e_src_d [NSRC];
  logic [NSRC-1:0] e_used_q, e_used_d;
  logic            e_div_q, e_div_d;
  logic [CntW-1:0] md_cnt_q, md_cnt_d;

  logic             d_hit   [NSRC];
  logic [SELW-1:0]  d_stage [NSRC];
  logic [TnewW-1:0] d_tnew  [NSRC];
  logic             e_hit   [NSRC];
  logic [SELW-1:0]  e_stage [NSRC];
  logic [TnewW-1:0] e_tnew  [NSRC];

  logic [NSRC-1:0] src_stall;
  logic            md_stall;
  logic            accept;

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    hazard_match #(
      .Depth     (DEPTH),
      .FirstStage(1)
    ) u_match_d (
      .src_i  (d_src_addr[s*5 +: 5]),
      .recs_i (recs_q),
      .hit_o  (d_hit[s]),
      .stage_o(d_stage[s]),
      .tnew_o (d_tnew[s])
    );

    // E-stage operands can only forward from M onwards.
    hazard_match #(
      .Depth     (DEPTH),
      .FirstStage(2)
    ) u_match_e (
      .src_i  (e_src_q[s]),
      .recs_i (recs_q),
      .hit_o  (e_hit[s]),
      .stage_o(e_stage[s]),
      .tnew_o (e_tnew[s])
    );
  end

  // Stall and forward selects.
  always_comb begin
    src_stall = '0;
    fwd_sel_d = '0;
    fwd_sel_e = '0;
    for (int s = 0; s < int'(NSRC); s++) begin
      src_stall[s] = d_src_used[s] && d_hit[s] &&
                     (d_tnew[s] > TnewW'(d_src_tuse[s*TW +: TW]));
      fwd_sel_d[s*SELW +: SELW] = (d_hit[s] && (d_tnew[s] == '0)) ? d_stage[s] : SELW'(FWD_RF);
      fwd_sel_e[s*SELW +: SELW] = (e_used_q[s] && e_hit[s] && (e_tnew[s] == '0)) ?
                                  e_stage[s] : SELW'(FWD_RF);
    end
  end

  assign md_busy  = (md_cnt_q != '0);
  // An MD op sitting in E has not loaded the counter yet but still blocks HI/LO access.
  assign md_stall = d_md_use && (md_busy || (recs_q[0].valid && recs_q[0].md));
  assign stall    = d_valid && ((|src_stall) || md_stall);
  assign accept   = d_valid && !stall && !flush;

  // Record shift and stage-1 load.
  always_comb begin
    recs_d[0] = '0;
    e_src_d   = '{default: '0};
    e_used_d  = '0;
    e_div_d   = 1'b0;
    if (accept) begin
      recs_d[0].valid = 1'b1;
      recs_d[0].dst   = d_dst_addr;
      recs_d[0].tnew  = TnewW'(d_dst_tnew);
      recs_d[0].md    = d_md_start;
      e_used_d        = d_src_used;
      e_div_d         = d_md_div;
      for (int s = 0; s < int'(NSRC); s++) begin
        e_src_d[s] = d_src_addr[s*5 +: 5];
      end
    end
    for (int k = 1; k < int'(DEPTH); k++) begin
      recs_d[k]      = recs_q[k-1];
      recs_d[k].tnew = (recs_q[k-1].tnew != '0) ? recs_q[k-1].tnew - TnewW'(1) : '0;
      // Flush kills everything in stages 1..DEPTH-1; the old W record leaves anyway.
      if (flush) begin
        recs_d[k].valid = 1'b0;
      end
    end
  end

  // MD busy counter: loads as the MD op leaves E, then counts down to zero.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (recs_q[0].valid && recs_q[0].md) begin
      md_cnt_d = e_div_q ? CntW'(DIV_CYC) : CntW'(MUL_CYC);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        recs_q[k] <= '0;
      end
      for (int s = 0; s < int'(NSRC); s++) begin
        e_src_q[s] <= '0;
      end
      e_used_q <= '0;
      e_div_q  <= 1'b0;
      md_cnt_q <= '0;
    end else begin
      recs_q   <= recs_d;
      e_src_q  <= e_src_d;
      e_used_q <= e_used_d;
      e_div_q  <= e_div_d;
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with default parameters (NSRC 2, DEPTH 3, TW 2).
module tb_hazard_scoreboard;

  localparam int unsigned NSRC = 2;
  localparam int unsigned TW   = 2;
  localparam int unsigned SELW = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 d_valid;
  logic [NSRC*5-1:0]    d_src_addr;
  logic [NSRC-1:0]      d_src_used;
  logic [NSRC*TW-1:0]   d_src_tuse;
  logic [4:0]           d_dst_addr;
  logic [TW-1:0]        d_dst_tnew;
  logic                 d_md_start;
  logic                 d_md_div;
  logic                 d_md_use;
  logic                 flush;
  logic                 stall;
  logic [NSRC*SELW-1:0] fwd_sel_d;
  logic [NSRC*SELW-1:0] fwd_sel_e;
  logic                 md_busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_scoreboard u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .d_valid   (d_valid),
    .d_src_addr(d_src_addr),
    .d_src_used(d_src_used),
    .d_src_tuse(d_src_tuse),
    .d_dst_addr(d_dst_addr),
    .d_dst_tnew(d_dst_tnew),
    .d_md_start(d_md_start),
    .d_md_div  (d_md_div),
    .d_md_use  (d_md_use),
    .flush     (flush),
    .stall     (stall),
    .fwd_sel_d (fwd_sel_d),
    .fwd_sel_e (fwd_sel_e),
    .md_busy   (md_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic v, input logic [4:0] s0, input logic u0, input logic [1:0] t0,
                       input logic [4:0] s1, input logic u1, input logic [1:0] t1,
                       input logic [4:0] dst, input logic [1:0] tnew);
    d_valid    = v;
    d_src_addr = {s1, s0};
    d_src_used = {u1, u0};
    d_src_tuse = {t1, t0};
    d_dst_addr = dst;
    d_dst_tnew = tnew;
    d_md_start = 1'b0;
    d_md_div   = 1'b0;
    d_md_use   = 1'b0;
    #1;
  endtask

  task automatic set_md(input logic start, input logic div, input logic use_md);
    d_md_start = start;
    d_md_div   = div;
    d_md_use   = use_md;
    #1;
  endtask

  task automatic idle(input int n);
    set_d(1'b0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 2'd0);
    repeat (n) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    set_d(1'b0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 2'd0);
    repeat (2) tick();
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_fwd_d", 32'(fwd_sel_d), 32'd0);
    check_eq("rst_fwd_e", 32'(fwd_sel_e), 32'd0);
    check_eq("rst_busy", 32'(md_busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // lw $t0 (tnew 2) -> addu $t2,$t0,$t1 (tuse 1)
    set_d(1'b1, 5'd29, 1'b1, 2'd1, 5'd0, 1'b0, 2'd0, 5'd8, 2'd2);
    check_eq("lw_issue_stall", 32'(stall), 32'd0);
    tick();
    set_d(1'b1, 5'd8, 1'b1, 2'd1, 5'd9, 1'b1, 2'd1, 5'd10, 2'd1);
    check_eq("lwuse_stall", 32'(stall), 32'd1);
    tick();
    check_eq("lwuse_release", 32'(stall), 32'd0);
    check_eq("lwuse_fwd_d", 32'(fwd_sel_d), 32'd0);
    tick();
    set_d(1'b0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 2'd0);
    check_eq("lwuse_fwd_e_w", 32'(fwd_sel_e), 32'h3);
    idle(3);

    // addu $t1 (tnew 1) -> beq $t1 (tuse 0)
    set_d(1'b1, 5'd16, 1'b1, 2'd1, 5'd17, 1'b1, 2'd1, 5'd9, 2'd1);
    check_eq("alu_issue_stall", 32'(stall), 32'd0);
    tick();
    set_d(1'b1, 5'd9, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 2'd0);
    check_eq("beq_stall", 32'(stall), 32'd1);
    tick();
    check_eq("beq_release", 32'(stall), 32'd0);
    check_eq("beq_fwd_d_m", 32'(fwd_sel_d), 32'h2);
    idle(4);

    // Write to $0 then read $0: never a hazard
    set_d(1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 2'd2);
    tick();
    set_d(1'b1, 5'd0, 1'b1, 2'd0, 5'd0, 1'b1, 2'd0, 5'd11, 2'd1);
    check_eq("zero_stall", 32'(stall), 32'd0);
    check_eq("zero_fwd_d", 32'(fwd_sel_d), 32'd0);
    tick();
    set_d(1'b0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 2'd0);
    check_eq("zero_fwd_e", 32'(fwd_sel_e), 32'd0);
    idle(4);

    // Two writers of $t2, both tnew 0: youngest wins
    set_d(1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd10, 2'd0);
    tick();
    set_d(1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd10, 2'd0);
    check_eq("ww_second_stall", 32'(stall), 32'd0);
    tick();
    set_d(1'b1, 5'd10, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0, 5'd12, 2'd1);
    check_eq("ww_stall", 32'(stall), 32'd0);
    check_eq("ww_fwd_d_e", 32'(fwd_sel_d), 32'h1);
    tick();
    set_d(1'b0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 2'd0);
    check_eq("ww_fwd_e_m", 32'(fwd_sel_e), 32'h2);
    idle(4);

    // div then mflo
    set_d(1'b1, 5'd8, 1'b1, 2'd1, 5'd9, 1'b1, 2'd1, 5'd0, 2'd0);
    set_md(1'b1, 1'b1, 1'b1);
    check_eq("div_issue_stall", 32'(stall), 32'd0);
    tick();
    set_d(1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd11, 2'd1);
    set_md(1'b0, 1'b0, 1'b1);
    check_eq("mflo_e_stall", 32'(stall), 32'd1);
    check_eq("mflo_e_busy", 32'(md_busy), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq($sformatf("div_busy_%0d", i), 32'(md_busy), 32'd1);
      check_eq($sformatf("mflo_stall_%0d", i), 32'(stall), 32'd1);
    end
    tick();
    check_eq("div_busy_end", 32'(md_busy), 32'd0);
    check_eq("mflo_release", 32'(stall), 32'd0);

    // div followed back-to-back by mult
    tick();
    set_d(1'b1, 5'd8, 1'b1, 2'd1, 5'd9, 1'b1, 2'd1, 5'd0, 2'd0);
    set_md(1'b1, 1'b1, 1'b1);
    check_eq("div2_issue_stall", 32'(stall), 32'd0);
    tick();
    set_d(1'b1, 5'd8, 1'b1, 2'd1, 5'd9, 1'b1, 2'd1, 5'd0, 2'd0);
    set_md(1'b1, 1'b0, 1'b1);
    check_eq("mult_e_stall", 32'(stall), 32'd1);
    repeat (10) tick();
    check_eq("mult_last_busy", 32'(md_busy), 32'd1);
    check_eq("mult_last_stall", 32'(stall), 32'd1);
    tick();
    check_eq("mult_release", 32'(stall), 32'd0);
    tick();
    set_d(1'b0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 2'd0);
    check_eq("mult_in_e_busy", 32'(md_busy), 32'd0);
    tick();
    check_eq("mult_busy", 32'(md_busy), 32'd1);
    idle(6);
    check_eq("mult_done", 32'(md_busy), 32'd0);

    // Flush with lw in E and a dependent in D
    set_d(1'b1, 5'd29, 1'b1, 2'd1, 5'd0, 1'b0, 2'd0, 5'd8, 2'd2);
    tick();
    set_d(1'b1, 5'd8, 1'b1, 2'd1, 5'd9, 1'b1, 2'd1, 5'd10, 2'd1);
    check_eq("flush_pre_stall", 32'(stall), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check_eq("flush_stall", 32'(stall), 32'd0);
    check_eq("flush_fwd_d", 32'(fwd_sel_d), 32'd0);
    tick();
    set_d(1'b0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 2'd0);
    check_eq("flush_fwd_e", 32'(fwd_sel_e), 32'd0);
    idle(3);

    // Reset asserted mid-div
    set_d(1'b1, 5'd8, 1'b1, 2'd1, 5'd9, 1'b1, 2'd1, 5'd0, 2'd0);
    set_md(1'b1, 1'b1, 1'b1);
    tick();
    set_d(1'b0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 2'd0);
    tick();
    tick();
    check_eq("div3_busy", 32'(md_busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_busy", 32'(md_busy), 32'd0);
    check_eq("async_rst_fwd_e", 32'(fwd_sel_e), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    set_d(1'b1, 5'd8, 1'b1, 2'd0, 5'd9, 1'b1, 2'd0, 5'd10, 2'd1);
    set_md(1'b0, 1'b0, 1'b1);
    check_eq("post_rst_stall", 32'(stall), 32'd0);
    check_eq("post_rst_fwd_d", 32'(fwd_sel_d), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding unit for the pipelined MIPS core with multiply/divide support and exception flush. It keeps a registered record for each in-flight instruction downstream of D (stage 1 = E … stage DEPTH = W), and computes the D-stage stall from Tuse/Tnew. It also computes forward selects for D-stage and E-stage operands and runs a busy counter for the multi-cycle MD unit. It replaces per-stage instruction re-decoding: the D stage presents one decoded record per cycle.

## Interface
- NSRC, 2: source operands per instruction.
- DEPTH, 3: tracked stages after D (1 = E, 2 = M, 3 = W); minimum 2.
- TW, 2: width of Tuse/Tnew fields.
- MUL_CYC, 5: MD busy cycles for mult/multu.
- DIV_CYC, 10: MD busy cycles for div/divu.
- SELW = $clog2(DEPTH+1): derived localparam for forward-select width.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- d_valid  in  1  D stage holds a real instruction.
- d_src_addr  in  NSRC*5  source register numbers.
- d_src_used  in  NSRC  source operand is read.
- d_src_tuse  in  NSRC*TW  cycles after D until the operand is consumed.
- d_dst_addr  in  5  destination register; 0 = no write.
- d_dst_tnew  in  TW  cycles after entering E until the result exists.
- d_md_start  in  1  instruction is mult/multu/div/divu.
- d_md_div  in  1  with d_md_start: division.
- d_md_use  in  1  instruction is mfhi/mflo/mthi/mtlo or starts MD.
- flush  in  1  exception/eret flush of stages 1..DEPTH-1.
- stall  out  1  freeze PC and F/D register, insert bubble into E.
- fwd_sel_d  out  NSRC*SELW  per D source: 0 = register file, k = forward from stage k.
- fwd_sel_e  out  NSRC*SELW  per E source: 0 = pipeline register value, k ∈ 2..DEPTH.
- md_busy  out  1  MD counter non-zero.

## Operation
- Record per stage k: valid, dst, tnew, md, plus src[NSRC]/used[NSRC] for stage 1.
- Each cycle records shift k → k+1. Carried tnew = max(tnew−1, 0). Record DEPTH is dropped.
- Stage 1 load:
  - If d_valid && !stall: takes the D fields.
  - Otherwise: bubble (valid = 0).
- Match rule: a record matches source s when valid && dst == src && dst != 0. The youngest match (smallest k) wins.
- Stall rule: stall_s = used_s && youngest match exists && tnew_k > tuse_s.
- MD stall: d_md_use && (md_busy || (rec1.valid && rec1.md)).
- stall = d_valid && (any stall_s || MD stall). Stall is never raised for d_valid = 0.
- fwd_sel_d[s] = k when the youngest match has tnew == 0, else 0. A non-stalled pending operand is resolved later by fwd_sel_e.
- fwd_sel_e[s]: same rule over stages 2..DEPTH, using rec1.src/used.
- MD counter:
  - Loads MUL_CYC or DIV_CYC on the edge where rec1.valid && rec1.md.
  - Otherwise decrements to 0 and saturates.
  - A load while non-zero cannot occur (stalled).
- Flush:
  - Invalidates records 1..DEPTH-1. Record DEPTH still shifts out and commits.
  - Stage 1 loads a bubble.
  - The MD counter is untouched.
- Flush and stall in the same cycle: flush wins; the D instruction is discarded upstream.

## Timing
- Reset: all records invalid; MD counter 0; stall, md_busy, fwd_sel_d and fwd_sel_e all 0.
- stall, fwd_sel_d and fwd_sel_e are combinational from the current records and D inputs, valid in the same cycle.
- An accepted D record appears as stage 1 in the next cycle.
- md_busy rises the cycle after the MD instruction leaves stage 1 and stays high exactly MUL_CYC/DIV_CYC cycles.
- Reset asserted mid-operation clears everything immediately (asynchronous). The first accepted instruction after release sees no hazards.

## Structure
- Shared package (`hazard_pkg`):
  - record struct type;
  - SELW function;
  - FWD_RF = 0 constant;
  - MUL_CYC/DIV_CYC defaults alongside the existing `define.v` forwarding codes.
- One sub-module, `hazard_match`: combinational youngest-match search (inputs: source address and record array; outputs: hit, stage index, tnew). Instantiated NSRC times for D and NSRC times for E.

## Test plan
- lw $t0 (tnew 2) then addu using $t0 (tuse 1): stall = 1 for one cycle, then fwd_sel_d = 0 and fwd_sel_e = 3 (W).
- addu $t1 (tnew 1) then beq on $t1 (tuse 0): stall for 1 cycle, then fwd_sel_d = 2 (M).
- Write to $0 followed by a reader of $0: stall = 0 and fwd_sel = 0 in every cycle.
- Two writers of $t2 in stages 1 and 2, both tnew 0: fwd_sel_d = 1 (youngest wins).
- div then mflo (DIV_CYC = 10): md_busy high exactly 10 cycles; mflo stalled until md_busy falls; mult issued back-to-back after a div stalls likewise.
- flush with a lw in stage 1 and a dependent instruction in D: records 1..DEPTH-1 are cleared and no stall is raised next cycle. Reset asserted mid-div: md_busy = 0 immediately.
